// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Request/ready bus between the instruction fetch unit and instruction memory.
//   imem_req   : fetch unit requests an instruction word
//   imem_addr  : fetch address (PC_W bits)
//   imem_ready : memory has imem_rdata valid this cycle
//   imem_rdata : 32-bit instruction word
// Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
  parameter int PC_W = 64
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Holds the PC, fetches one instruction at a time from instruction memory over
// a request/ready handshake, holds it for the control decoder until accepted,
// then advances the PC by 4 or by a taken branch offset.
//
// Ports:
//   CLK, Reset            : clock, synchronous active-high reset
//   startpc               : PC loaded while Reset is high
//   imem (master modport) : imem_req / imem_addr / imem_ready / imem_rdata
//   instr_valid/ready     : handshake towards the consumer
//   instr, opcode, pc_out : held instruction, instr[31:21], its PC
//   branch, uncond_branch, zero, signext_imm : next-PC controls (used on accept)
//   fault                 : sticky fetch-timeout flag, cleared only by Reset
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters
//   perf_fetched, perf_mem_wait, perf_taken (CNT_W bits each).
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int PC_W           = 64,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [PC_W-1:0]           startpc,
  instruction_fetch_unit_if.master  imem,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [31:0]               instr,
  output logic [10:0]               opcode,
  output logic [PC_W-1:0]           pc_out,
  input  logic                      branch,
  input  logic                      uncond_branch,
  input  logic                      zero,
  input  logic [PC_W-1:0]           signext_imm,
  output logic                      fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          perf_fetched,
  output logic [CNT_W-1:0]          perf_mem_wait,
  output logic [CNT_W-1:0]          perf_taken
`endif
);

  // Wait counter only has to reach TIMEOUT_CYCLES-1.
  localparam int              WAIT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   next_pc_s;
  logic [31:0]       instr_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              fault_r;
  logic              imem_req_s;
  logic              instr_valid_s;
  logic              mem_hit_s;
  logic              accept_s;
  logic              timeout_s;
  logic              taken_s;

  // Next-state and handshake decode from the current state.
  always_comb begin
    state_s       = state_r;
    imem_req_s    = 1'b0;
    instr_valid_s = 1'b0;
    mem_hit_s     = 1'b0;
    accept_s      = 1'b0;
    timeout_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem.imem_ready) begin
          mem_hit_s = 1'b1;
          state_s   = ST_HOLD;
        end else if (TIMEOUT_EN && (wait_cnt_r == WAIT_LAST)) begin
          timeout_s = 1'b1;
          state_s   = ST_FAULT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        instr_valid_s = 1'b1;
        if (instr_ready) begin
          accept_s = 1'b1;
          state_s  = ST_FETCH;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_FAULT: begin
        state_s = ST_FAULT;
      end
      default: begin
        state_s = ST_FETCH;
      end
    endcase
  end

  // Branch resolution; uncond_branch wins so an unknown branch cannot leak in.
  always_comb begin
    if (uncond_branch) begin
      taken_s = 1'b1;
    end else if (branch && zero) begin
      taken_s = 1'b1;
    end else begin
      taken_s = 1'b0;
    end
    if (taken_s) begin
      next_pc_s = pc_r + (signext_imm << 2);
    end else begin
      next_pc_s = pc_r + PC_W'(4);
    end
  end

  // State, PC, instruction, wait counter and sticky fault registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r    <= ST_FETCH;
      pc_r       <= startpc;
      instr_r    <= 32'd0;
      wait_cnt_r <= '0;
      fault_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        pc_r <= next_pc_s;
      end
      if (mem_hit_s) begin
        instr_r    <= imem.imem_rdata;
        wait_cnt_r <= '0;
      end else if (state_r == ST_FETCH) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
      if (timeout_s) begin
        fault_r <= 1'b1;
      end
    end
  end

  assign imem.imem_req  = imem_req_s;
  assign imem.imem_addr = pc_r;
  assign instr_valid    = instr_valid_s;
  assign instr          = instr_r;
  assign opcode         = instr_r[31:21];
  assign pc_out         = pc_r;
  assign fault          = fault_r;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] perf_fetched_r;
  logic [CNT_W-1:0] perf_mem_wait_r;
  logic [CNT_W-1:0] perf_taken_r;

  // Saturating event counters.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      perf_fetched_r  <= '0;
      perf_mem_wait_r <= '0;
      perf_taken_r    <= '0;
    end else begin
      if (accept_s && (perf_fetched_r != {CNT_W{1'b1}})) begin
        perf_fetched_r <= perf_fetched_r + CNT_W'(1);
      end
      if ((state_r == ST_FETCH) && !imem.imem_ready &&
          (perf_mem_wait_r != {CNT_W{1'b1}})) begin
        perf_mem_wait_r <= perf_mem_wait_r + CNT_W'(1);
      end
      if (accept_s && taken_s && (perf_taken_r != {CNT_W{1'b1}})) begin
        perf_taken_r <= perf_taken_r + CNT_W'(1);
      end
    end
  end

  assign perf_fetched  = perf_fetched_r;
  assign perf_mem_wait = perf_mem_wait_r;
  assign perf_taken    = perf_taken_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Self-checking bench for instruction_fetch_unit. A scoreboard queue records
// each word handed to the DUT together with the PC it was fetched from; the
// entry is popped and compared when instr_valid appears. The bench keeps its
// own PC model and, with FETCH_PERF_CNT_EN, its own event counts.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
  localparam int PC_W  = 64;
  localparam int TO    = 8;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     word;
  } sb_t;

  logic            CLK = 1'b0;
  logic            Reset;
  logic [PC_W-1:0] startpc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [10:0]     opcode;
  logic [PC_W-1:0] pc_out;
  logic            branch;
  logic            uncond_branch;
  logic            zero;
  logic [PC_W-1:0] signext_imm;
  logic            fault;
`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] perf_fetched;
  logic [CNT_W-1:0] perf_mem_wait;
  logic [CNT_W-1:0] perf_taken;
`endif

  instruction_fetch_unit_if #(.PC_W(PC_W)) imem_if ();

  instruction_fetch_unit #(
    .PC_W(PC_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .Reset(Reset), .startpc(startpc), .imem(imem_if),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .pc_out(pc_out), .branch(branch),
    .uncond_branch(uncond_branch), .zero(zero), .signext_imm(signext_imm),
    .fault(fault)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_mem_wait(perf_mem_wait),
    .perf_taken(perf_taken)
`endif
  );

  always #5 CLK = ~CLK;

  sb_t             sb_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [PC_W-1:0] exp_pc;
  int              exp_fetched;
  int              exp_wait;
  int              exp_taken;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input logic [PC_W-1:0] spc);
    Reset = 1'b1;
    startpc = spc;
    imem_if.imem_ready = 1'b0;
    imem_if.imem_rdata = 32'd0;
    instr_ready = 1'b0;
    branch = 1'b0;
    uncond_branch = 1'b0;
    zero = 1'b0;
    signext_imm = '0;
    step();
    step();
    Reset = 1'b0;
    exp_pc = spc;
    sb_q.delete();
    exp_fetched = 0;
    exp_wait = 0;
    exp_taken = 0;
  endtask

  // One full fetch: `delay` wait cycles, then ready, `hold` stall cycles, accept.
  task automatic fetch_one(input int delay, input logic [31:0] word, input int hold,
                           input logic br, input logic ub, input logic z,
                           input logic [PC_W-1:0] imm);
    sb_t  e;
    logic tk;
    for (int i = 0; i < delay; i++) begin
      n_checks++;
      if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== exp_pc || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_req: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                 imem_if.imem_req, imem_if.imem_addr, instr_valid, exp_pc);
      end
      imem_if.imem_ready = 1'b0;
      instr_ready = 1'b1;
      exp_wait++;
      step();
    end
    instr_ready = 1'b0;
    n_checks++;
    if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL req_addr: req=%b addr=%h, required req=1 addr=%h",
               imem_if.imem_req, imem_if.imem_addr, exp_pc);
    end
    imem_if.imem_ready = 1'b1;
    imem_if.imem_rdata = word;
    sb_q.push_back('{pc: exp_pc, word: word});
    step();
    imem_if.imem_ready = 1'b0;
    imem_if.imem_rdata = ~word;
    n_checks++;
    if (instr_valid !== 1'b1 || imem_if.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_valid: valid=%b req=%b, required valid=1 req=0",
               instr_valid, imem_if.imem_req);
    end
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got 0 entries, required 1");
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    n_checks++;
    if (instr !== e.word || opcode !== e.word[31:21] || pc_out !== e.pc) begin
      n_fail++;
      $display("FAIL hold_data: instr=%h opcode=%h pc_out=%h, required %h %h %h",
               instr, opcode, pc_out, e.word, e.word[31:21], e.pc);
    end
    for (int j = 0; j < hold; j++) begin
      imem_if.imem_ready = 1'b1;
      instr_ready = 1'b0;
      branch = 1'b1;
      uncond_branch = 1'b1;
      signext_imm = 64'h123;
      step();
      n_checks++;
      if (instr !== e.word || opcode !== e.word[31:21] || pc_out !== e.pc ||
          imem_if.imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_stable: instr=%h pc_out=%h req=%b valid=%b, required %h %h 0 1",
                 instr, pc_out, imem_if.imem_req, instr_valid, e.word, e.pc);
      end
    end
    imem_if.imem_ready = 1'b0;
    instr_ready = 1'b1;
    branch = br;
    uncond_branch = ub;
    zero = z;
    signext_imm = imm;
    step();
    instr_ready = 1'b0;
    branch = 1'b0;
    uncond_branch = 1'b0;
    zero = 1'b0;
    signext_imm = '0;
    if (ub === 1'b1) tk = 1'b1;
    else tk = (br === 1'b1) && (z === 1'b1);
    exp_fetched++;
    if (tk) begin
      exp_taken++;
      exp_pc = exp_pc + (imm << 2);
    end else begin
      exp_pc = exp_pc + 64'd4;
    end
    n_checks++;
    if (instr_valid !== 1'b0 || imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL next_addr: valid=%b req=%b addr=%h, required valid=0 req=1 addr=%h",
               instr_valid, imem_if.imem_req, imem_if.imem_addr, exp_pc);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    startpc = 64'h40;
    imem_if.imem_ready = 1'b1;
    imem_if.imem_rdata = 32'hDEADBEEF;
    instr_ready = 1'b1;
    branch = 1'b0;
    uncond_branch = 1'b0;
    zero = 1'b0;
    signext_imm = '0;
    step();
    step();
    n_checks++;
    if (imem_if.imem_req !== 1'b1 || instr_valid !== 1'b0 || fault !== 1'b0 ||
        imem_if.imem_addr !== 64'h40 || instr !== 32'd0 || pc_out !== 64'h40) begin
      n_fail++;
      $display("FAIL reset_state: req=%b valid=%b fault=%b addr=%h instr=%h pc_out=%h, required 1 0 0 40 0 40",
               imem_if.imem_req, instr_valid, fault, imem_if.imem_addr, instr, pc_out);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_fetched !== '0 || perf_mem_wait !== '0 || perf_taken !== '0) begin
      n_fail++;
      $display("FAIL reset_perf: %0d %0d %0d, required 0 0 0", perf_fetched, perf_mem_wait, perf_taken);
    end
`endif
  endtask

  task automatic test_stream();
    apply_reset(64'h40);
    for (int k = 0; k < 3; k++) begin
      fetch_one(0, 32'h8B020020, 0, 1'b0, 1'b0, 1'b0, '0);
    end
    n_checks++;
    if (opcode !== 11'h458 || exp_pc !== 64'h4C) begin
      n_fail++;
      $display("FAIL stream_opcode: opcode=%h model_pc=%h, required 458 4c", opcode, exp_pc);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset(64'h100);
    fetch_one(3, 32'hF8400020, 0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_hold_stall();
    fetch_one(0, 32'hD2800041, 5, 1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (imem_if.imem_addr !== 64'h108) begin
      n_fail++;
      $display("FAIL stall_next_pc: addr=%h, required 108", imem_if.imem_addr);
    end
  endtask

  task automatic test_branches();
    apply_reset(64'h48);
    fetch_one(0, 32'hB4000040, 0, 1'b1, 1'b0, 1'b1, -64'sd2);
    n_checks++;
    if (imem_if.imem_addr !== 64'h40) begin
      n_fail++;
      $display("FAIL br_taken: addr=%h, required 40", imem_if.imem_addr);
    end
    apply_reset(64'h48);
    fetch_one(0, 32'hB4000040, 0, 1'b1, 1'b0, 1'b0, 64'h20);
    n_checks++;
    if (imem_if.imem_addr !== 64'h4C) begin
      n_fail++;
      $display("FAIL br_not_taken: addr=%h, required 4c", imem_if.imem_addr);
    end
    apply_reset(64'h48);
    fetch_one(0, 32'h14000010, 0, 1'bx, 1'b1, 1'b0, 64'h10);
    n_checks++;
    if (imem_if.imem_addr !== 64'h88) begin
      n_fail++;
      $display("FAIL br_uncond: addr=%h, required 88", imem_if.imem_addr);
    end
    apply_reset(64'hFFFF_FFFF_FFFF_FFFC);
    fetch_one(0, 32'h8B020020, 0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (imem_if.imem_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: addr=%h, required 0", imem_if.imem_addr);
    end
  endtask

  task automatic test_timeout();
    apply_reset(64'h300);
    for (int i = 0; i < TO; i++) begin
      n_checks++;
      if (imem_if.imem_req !== 1'b1 || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL to_wait: cycle %0d req=%b fault=%b, required req=1 fault=0",
                 i, imem_if.imem_req, fault);
      end
      step();
    end
    n_checks++;
    if (fault !== 1'b1 || imem_if.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fault: fault=%b req=%b valid=%b, required 1 0 0",
               fault, imem_if.imem_req, instr_valid);
    end
    imem_if.imem_ready = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (fault !== 1'b1 || imem_if.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_sticky: fault=%b req=%b valid=%b, required 1 0 0",
               fault, imem_if.imem_req, instr_valid);
    end
    apply_reset(64'h300);
    n_checks++;
    if (fault !== 1'b0 || imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 64'h300) begin
      n_fail++;
      $display("FAIL to_recover: fault=%b req=%b addr=%h, required 0 1 300",
               fault, imem_if.imem_req, imem_if.imem_addr);
    end
    fetch_one(1, 32'h91000421, 0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid_hold();
    apply_reset(64'h40);
    fetch_one(2, 32'hAA0103E2, 1, 1'b1, 1'b1, 1'b1, 64'h4);
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_fetched !== CNT_W'(exp_fetched) || perf_mem_wait !== CNT_W'(exp_wait) ||
        perf_taken !== CNT_W'(exp_taken)) begin
      n_fail++;
      $display("FAIL perf_counts: %0d %0d %0d, required %0d %0d %0d",
               perf_fetched, perf_mem_wait, perf_taken, exp_fetched, exp_wait, exp_taken);
    end
`endif
    imem_if.imem_ready = 1'b1;
    imem_if.imem_rdata = 32'h12345678;
    step();
    imem_if.imem_ready = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_hold_entry: valid=%b, required 1", instr_valid);
    end
    Reset = 1'b1;
    startpc = 64'h200;
    imem_if.imem_ready = 1'b1;
    step();
    n_checks++;
    if (instr_valid !== 1'b0 || imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 64'h200) begin
      n_fail++;
      $display("FAIL mid_hold_reset: valid=%b req=%b addr=%h, required 0 1 200",
               instr_valid, imem_if.imem_req, imem_if.imem_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_fetched !== '0 || perf_mem_wait !== '0 || perf_taken !== '0) begin
      n_fail++;
      $display("FAIL mid_hold_perf: %0d %0d %0d, required 0 0 0", perf_fetched, perf_mem_wait, perf_taken);
    end
`endif
    step();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ignores_ready: valid=%b, required 0", instr_valid);
    end
    Reset = 1'b0;
    imem_if.imem_ready = 1'b0;
    exp_pc = 64'h200;
    sb_q.delete();
    exp_fetched = 0;
    exp_wait = 0;
    exp_taken = 0;
    fetch_one(0, 32'hCB020020, 0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  r;
    logic [31:0] w;
    apply_reset(64'h1000);
    for (int k = 0; k < 8; k++) begin
      r = 8'($urandom_range(0, 255));
      w = $urandom();
      fetch_one(int'($urandom_range(0, 2)), w, int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), {{56{r[7]}}, r});
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_fetched !== CNT_W'(exp_fetched) || perf_mem_wait !== CNT_W'(exp_wait) ||
        perf_taken !== CNT_W'(exp_taken)) begin
      n_fail++;
      $display("FAIL b2b_perf: %0d %0d %0d, required %0d %0d %0d",
               perf_fetched, perf_mem_wait, perf_taken, exp_fetched, exp_wait, exp_taken);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mem_wait();
    test_hold_stall();
    test_branches();
    test_timeout();
    test_reset_mid_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the single-cycle control decoder.
- Holds the PC and runs a request/ready handshake to instruction memory.
- Registers the fetched 32-bit instruction and presents instr[31:21] as the opcode to the control decoder.
- Computes the next PC from the decoder's branch / uncond_branch outputs and the ALU zero flag when the consumer accepts the instruction.

Parameters:
- PC_W, 64: PC / address width.
- TIMEOUT_CYCLES, 255: cycles allowed in FETCH without imem_ready before faulting; 0 disables the watchdog.
- CNT_W, 32: width of the optional performance counters.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- startpc  in  PC_W  PC loaded during reset.
- imem_req  out  1  instruction memory request.
- imem_addr  out  PC_W  fetch address (equals pc).
- imem_ready  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/opcode/pc_out valid.
- instr_ready  in  1  consumer accepts the current instruction.
- instr  out  32  registered instruction.
- opcode  out  11  instr[31:21], feeds the control decoder.
- pc_out  out  PC_W  PC of the held instruction.
- branch  in  1  from the control decoder.
- uncond_branch  in  1  from the control decoder.
- zero  in  1  ALU zero flag.
- signext_imm  in  PC_W  sign-extended branch offset, in words.
- fault  out  1  sticky fetch-timeout flag.

Behaviour:
- States:
  - FETCH: imem_req=1.
  - HOLD: instr_valid=1.
  - FAULT: all handshakes idle.
- imem_req and instr_valid are decoded combinationally from state only. imem_addr=pc, pc_out=pc.
- Reset high (sampled at edge): pc<=startpc, state<=FETCH, instr<=0, wait counter<=0, fault<=0. While Reset is high, outputs read as FETCH but any imem_ready is ignored. Reset overrides every other event, including mid-FETCH and mid-HOLD.
- FETCH:
  - imem_ready=1 at edge: instr<=imem_rdata, counter<=0, state->HOLD.
  - Otherwise counter increments.
  - TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without ready: state->FAULT, fault<=1.
  - imem_addr is held stable throughout FETCH.
- Latency: ready in the same cycle as the request gives instr_valid on the next cycle. Peak throughput is one instruction per 2 cycles.
- HOLD:
  - instr, opcode and pc_out stay stable while instr_ready=0. No new request is issued.
  - instr_ready=1 at edge: pc<=next_pc, state->FETCH.
- next_pc:
  - Taken when uncond_branch | (branch & zero): next_pc = pc + (signext_imm << 2), modulo 2^PC_W (wrap, no overflow detect).
  - Otherwise: next_pc = pc + 4, also wrapping.
- Ignored inputs:
  - branch, uncond_branch, zero and signext_imm are ignored outside an accepting HOLD cycle.
  - X on branch while uncond_branch=1 must not affect the result; the taken condition is evaluated with uncond_branch priority.
- FAULT: imem_req=0, instr_valid=0, fault=1. Left only by Reset.
- imem_ready outside FETCH is ignored. instr_ready outside HOLD is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds three outputs, CNT_W bits each, all cleared by Reset and saturating at all-ones:
  - perf_fetched: increments per accepted instruction.
  - perf_mem_wait: increments per FETCH cycle with imem_ready=0.
  - perf_taken: increments per accepted instruction with a taken branch.
- When undefined, these ports and registers do not exist and all other behaviour is identical.

Test Plan:
- Reset with startpc=0x40, imem_ready tied 1, instr_ready tied 1, memory returns 0x8B020020 → imem_addr sequence 0x40, 0x44, 0x48 on alternate cycles; instr_valid one cycle after each request; opcode=0x458.
- imem_ready delayed 3 cycles at pc 0x100 → imem_req high 4 cycles with imem_addr stable at 0x100; instr_valid rises the cycle after ready.
- instr_ready low for 5 cycles in HOLD → instr, opcode and pc_out unchanged, imem_req=0 throughout; on accept, the next request goes to pc+4.
- Branch cases at pc 0x48:
  - branch=1, zero=1, signext_imm=-2 → next imem_addr 0x40.
  - branch=1, zero=0 → 0x4C.
  - uncond_branch=1, signext_imm=0x10 → 0x88.
- TIMEOUT_CYCLES=8, imem_ready never asserted → fault=1 after 8 FETCH cycles, imem_req drops; a later imem_ready is ignored; Reset clears fault and refetches startpc.
- Reset asserted mid-HOLD with startpc=0x200 → instr_valid=0 on the next cycle, imem_addr=0x200. With FETCH_PERF_CNT_EN defined, all counters read 0.
